// File: rtl/axi_perf_stat_fmt_if.sv
// Handshake bundle between the statistics formatter, its start requester and the UART byte sink.
// The slave view belongs to the formatter; the master view drives it.
interface axi_perf_stat_fmt_if #(
    parameter int STAT_WIDTH = 16,
    parameter int NUM_STATS  = 4
);
    logic                            start_valid;
    logic                            start_ready;
    logic [NUM_STATS*STAT_WIDTH-1:0] stats_i;
    logic                            tx_valid;
    logic [7:0]                      tx_data;
    logic                            tx_ready;
    logic                            busy;
    logic                            done;

    modport slave (
        input  start_valid, stats_i, tx_ready,
        output start_ready, tx_valid, tx_data, busy, done
    );

    modport master (
        output start_valid, stats_i, tx_ready,
        input  start_ready, tx_valid, tx_data, busy, done
    );
endinterface

// File: rtl/axi_perf_stat_fmt.sv
// Prints a latched snapshot of NUM_STATS counters as one "XXXX XXXX ...\r\n" ASCII hex line
// on a valid/ready byte stream.
module axi_perf_stat_fmt #(
    parameter int STAT_WIDTH = 16,
    parameter int NUM_STATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    axi_perf_stat_fmt_if.slave bus
);
    localparam int NIBBLES = STAT_WIDTH / 4;
    localparam int SIDX_W  = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
    localparam int NIDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(NUM_STATS - 1);
    localparam logic [NIDX_W-1:0] NIDX_TOP  = NIDX_W'(NIBBLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_SEP   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    state_t                          state_r;
    logic [NUM_STATS*STAT_WIDTH-1:0] snapshot_r;
    logic [SIDX_W-1:0]               stat_idx_r;
    logic [NIDX_W-1:0]               nib_idx_r;
    logic [7:0]                      tx_data_r;
    logic                            tx_valid_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            start_ready_r;

    logic [SIDX_W-1:0]     next_stat_s;
    logic [SIDX_W-1:0]     tgt_sidx_s;
    logic [NIDX_W-1:0]     tgt_nidx_s;
    logic [STAT_WIDTH-1:0] tgt_stat_s;
    logic [7:0]            next_digit_s;
    logic [7:0]            first_digit_s;

    // Pick the nibble that becomes the next digit; the target index is clamped so it never leaves range.
    always_comb begin
        next_stat_s = stat_idx_r;
        tgt_sidx_s  = stat_idx_r;
        tgt_nidx_s  = nib_idx_r;
        if (stat_idx_r != SIDX_LAST) begin
            next_stat_s = stat_idx_r + SIDX_W'(1);
        end else begin
            next_stat_s = stat_idx_r;
        end
        case (state_r)
            ST_DIGIT: begin
                if (nib_idx_r != '0) begin
                    tgt_nidx_s = nib_idx_r - NIDX_W'(1);
                end else begin
                    tgt_nidx_s = nib_idx_r;
                end
            end
            ST_SEP: begin
                tgt_sidx_s = next_stat_s;
                tgt_nidx_s = NIDX_TOP;
            end
            default: begin
                tgt_sidx_s = stat_idx_r;
                tgt_nidx_s = nib_idx_r;
            end
        endcase
        tgt_stat_s    = snapshot_r[int'(tgt_sidx_s)*STAT_WIDTH +: STAT_WIDTH];
        next_digit_s  = hex_ascii(tgt_stat_s[int'(tgt_nidx_s)*4 +: 4]);
        first_digit_s = hex_ascii(bus.stats_i[STAT_WIDTH-1 -: 4]);
    end

    // Line sequencer: state, indices and every registered output advance only on a byte accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            snapshot_r    <= '0;
            stat_idx_r    <= '0;
            nib_idx_r     <= '0;
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            start_ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_valid && start_ready_r) begin
                        snapshot_r    <= bus.stats_i;
                        stat_idx_r    <= '0;
                        nib_idx_r     <= NIDX_TOP;
                        tx_data_r     <= first_digit_s;
                        tx_valid_r    <= 1'b1;
                        busy_r        <= 1'b1;
                        start_ready_r <= 1'b0;
                        state_r       <= ST_DIGIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DIGIT: begin
                    if (bus.tx_ready) begin
                        if (nib_idx_r != '0) begin
                            nib_idx_r <= tgt_nidx_s;
                            tx_data_r <= next_digit_s;
                        end else if (stat_idx_r != SIDX_LAST) begin
                            tx_data_r <= 8'h20;
                            state_r   <= ST_SEP;
                        end else begin
                            tx_data_r <= 8'h0D;
                            state_r   <= ST_CR;
                        end
                    end else begin
                        state_r <= ST_DIGIT;
                    end
                end
                ST_SEP: begin
                    if (bus.tx_ready) begin
                        stat_idx_r <= next_stat_s;
                        nib_idx_r  <= NIDX_TOP;
                        tx_data_r  <= next_digit_s;
                        state_r    <= ST_DIGIT;
                    end else begin
                        state_r <= ST_SEP;
                    end
                end
                ST_CR: begin
                    if (bus.tx_ready) begin
                        tx_data_r <= 8'h0A;
                        state_r   <= ST_LF;
                    end else begin
                        state_r <= ST_CR;
                    end
                end
                ST_LF: begin
                    if (bus.tx_ready) begin
                        tx_valid_r    <= 1'b0;
                        done_r        <= 1'b1;
                        busy_r        <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_LF;
                    end
                end
                default: begin
                    tx_valid_r    <= 1'b0;
                    busy_r        <= 1'b0;
                    start_ready_r <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_valid    = tx_valid_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.start_ready = start_ready_r;
endmodule
